// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor: prediction modes,
// 2-bit counter encoding and the saturating counter step.
package branch_predictor_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned MODE_BTB     = 0;
    localparam int unsigned MODE_BIMODAL = 1;
    localparam int unsigned MODE_GSHARE  = 2;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Saturating step: taken moves toward CTR_ST, not-taken toward CTR_SNT.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, EX-resolve and perf-counter signals between the pipeline
// and the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned GHR_BITS = 8
);
    import branch_predictor_pkg::*;

    logic [XLEN-1:0]     pc_f;
    logic                pred_taken_f;
    logic [XLEN-1:0]     pred_npc_f;
    logic [GHR_BITS-1:0] ghr_f;

    logic                upd_en;
    logic [XLEN-1:0]     ex_pc;
    logic                ex_taken;
    logic [XLEN-1:0]     ex_target;
    logic                ex_pred_taken;
    logic [XLEN-1:0]     ex_pred_npc;
    logic [GHR_BITS-1:0] ex_ghr;
    logic                mispredict;
    logic [XLEN-1:0]     redirect_pc;

    logic                perf_clr;
    logic [XLEN-1:0]     br_count;
    logic [XLEN-1:0]     miss_count;

    modport slave (
        input  pc_f, upd_en, ex_pc, ex_taken, ex_target, ex_pred_taken,
               ex_pred_npc, ex_ghr, perf_clr,
        output pred_taken_f, pred_npc_f, ghr_f, mispredict, redirect_pc,
               br_count, miss_count
    );

    modport master (
        output pc_f, upd_en, ex_pc, ex_taken, ex_target, ex_pred_taken,
               ex_pred_npc, ex_ghr, perf_clr,
        input  pred_taken_f, pred_npc_f, ghr_f, mispredict, redirect_pc,
               br_count, miss_count
    );

endinterface

// File: rtl/bp_sat_counter_table.sv
// Array of 2-bit saturating counters: one async read port returning the
// taken bit, one write port that applies a saturating step to the entry.
module bp_sat_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 256,
    parameter ctr_t        INIT    = CTR_WNT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    output logic                       rd_taken_c_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
    input  logic                       wr_taken_i
);

    ctr_t ctr_q [ENTRIES];

    assign rd_taken_c_o = ctr_q[rd_idx_i][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= INIT;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit counter BHT with BTB-only, bimodal or gshare
// prediction; resolves branches from EX and keeps branch/mispredict counts.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned BHT_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 8,
    parameter int unsigned MODE        = MODE_BIMODAL,
    parameter ctr_t        CTR_INIT    = CTR_WNT
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bus
);

    localparam int unsigned BI    = $clog2(BTB_ENTRIES);
    localparam int unsigned BHI   = $clog2(BHT_ENTRIES);
    localparam int unsigned TAG_W = XLEN - BI - 2;

    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_q, ghr_d;
    logic [XLEN-1:0]        br_count_q, br_count_d;
    logic [XLEN-1:0]        miss_count_q, miss_count_d;

    logic [BI-1:0]    f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic [BHI-1:0]   f_hist, e_hist;
    logic [BHI-1:0]   f_bidx, e_bidx;
    logic             f_ctr_taken;
    logic             pred_taken;
    logic             mispredict;
    logic             bht_wr_en;

    // Fetch-side lookup
    assign f_idx  = bus.pc_f[BI+1:2];
    assign f_tag  = bus.pc_f[XLEN-1:BI+2];
    assign f_hit  = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    assign f_hist = (MODE == MODE_GSHARE) ? BHI'(ghr_q) : '0;
    assign f_bidx = bus.pc_f[BHI+1:2] ^ f_hist;

    assign pred_taken       = f_hit && ((MODE == MODE_BTB) || f_ctr_taken);
    assign bus.pred_taken_f = pred_taken;
    assign bus.pred_npc_f   = pred_taken ? btb_tgt_q[f_idx] : bus.pc_f + 32'd4;
    assign bus.ghr_f        = ghr_q;

    // Resolve side: the counter index uses the history carried with the branch
    assign e_idx  = bus.ex_pc[BI+1:2];
    assign e_tag  = bus.ex_pc[XLEN-1:BI+2];
    assign e_hit  = btb_valid_q[e_idx] && (btb_tag_q[e_idx] == e_tag);
    assign e_hist = (MODE == MODE_GSHARE) ? BHI'(bus.ex_ghr) : '0;
    assign e_bidx = bus.ex_pc[BHI+1:2] ^ e_hist;

    assign mispredict = bus.upd_en &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_pred_npc != bus.ex_target)));
    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    assign bus.br_count    = br_count_q;
    assign bus.miss_count  = miss_count_q;

    assign bht_wr_en = bus.upd_en && (MODE != MODE_BTB);

    bp_sat_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .INIT    (CTR_INIT)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (f_bidx),
        .rd_taken_c_o (f_ctr_taken),
        .wr_en_i      (bht_wr_en),
        .wr_idx_i     (e_bidx),
        .wr_taken_i   (bus.ex_taken)
    );

    always_comb begin
        btb_valid_d  = btb_valid_q;
        ghr_d        = ghr_q;
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (bus.upd_en) begin
            // Taken always claims the slot; BTB-only mode drops entries that fall through
            if (bus.ex_taken)                        btb_valid_d[e_idx] = 1'b1;
            else if ((MODE == MODE_BTB) && e_hit)    btb_valid_d[e_idx] = 1'b0;
            if (MODE == MODE_GSHARE) ghr_d = GHR_BITS'({ghr_q, bus.ex_taken});
            br_count_d   = br_count_q + 32'd1;
            miss_count_d = miss_count_q + XLEN'(mispredict);
        end
        if (bus.perf_clr) begin
            br_count_d   = '0;
            miss_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid_q  <= '0;
            ghr_q        <= '0;
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            btb_valid_q  <= btb_valid_d;
            ghr_q        <= ghr_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tag/target payload is only meaningful behind a valid bit, so it has no reset
    always_ff @(posedge clk) begin
        if (bus.upd_en && bus.ex_taken) begin
            btb_tag_q[e_idx] <= e_tag;
            btb_tgt_q[e_idx] <= bus.ex_target;
        end
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised successor to the BTB-only predictor. It combines a direct-mapped BTB with a 2-bit-counter BHT and selects between BTB-only, bimodal and gshare modes.
- Fetch side: looks up PCF combinationally and supplies the predicted next PC.
- Resolve side: updates state from the EX stage and raises a mispredict redirect toward the NPC generator and hazard unit.
- Also keeps branch and mispredict performance counters.

Parameters:
BTB_ENTRIES, 64, number of BTB entries; power of two, 4..1024.
BHT_ENTRIES, 256, number of 2-bit counters; power of two, at least 4.
GHR_BITS, 8, global history length; must not exceed log2(BHT_ENTRIES).
MODE, 1, prediction mode: 0 = BTB-only (taken on hit), 1 = bimodal, 2 = gshare.
CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
pc_f  in  32  PC being fetched (PCF)
pred_taken_f  out  1  prediction for pc_f
pred_npc_f  out  32  predicted next PC: BTB target if pred_taken_f, else pc_f+4
ghr_f  out  GHR_BITS  history snapshot at lookup, carried down the pipe with the instruction
upd_en  in  1  EX holds a valid conditional branch this cycle (not stalled, not flushed)
ex_pc  in  32  PC of the resolving branch (PCE)
ex_taken  in  1  actual outcome (BranchE)
ex_target  in  32  actual taken target (BrNPC)
ex_pred_taken  in  1  prediction carried with the branch
ex_pred_npc  in  32  predicted NPC carried with the branch
ex_ghr  in  GHR_BITS  ghr_f carried with the branch
mispredict  out  1  flush request for IF/ID
redirect_pc  out  32  corrected PC: ex_target if ex_taken, else ex_pc+4
perf_clr  in  1  synchronous clear of the performance counters
br_count  out  32  resolved branches
miss_count  out  32  mispredicts

Behaviour:
Reset (asynchronous):
- All BTB valid bits 0; all counters CTR_INIT; GHR 0; br_count and miss_count 0.
- As a result, pred_taken_f = 0 and pred_npc_f = pc_f+4 from reset.

Lookup (combinational, zero latency):
- BI = log2(BTB_ENTRIES). Index = pc_f[BI+1:2]; tag = pc_f[31:BI+2].
- hit = valid[idx] && tag match.
- Counter index: MODE 1 uses pc_f[BHI+1:2]; MODE 2 uses the same bits XOR the GHR zero-extended to BHI bits, where BHI = log2(BHT_ENTRIES).
- pred_taken_f = hit && (MODE==0 ? 1 : ctr[bidx][1]).
- ghr_f = current GHR.

Mispredict (combinational):
- mispredict = upd_en && (ex_taken != ex_pred_taken || (ex_taken && ex_pred_npc != ex_target)).
- mispredict is 0 whenever upd_en = 0.

Update (posedge clk, when upd_en = 1):
- BTB on ex_taken: write valid=1, tag, and target=ex_target at the ex_pc index. This overwrites any alias (conflict replacement).
- BTB on not-taken: MODE 0 clears valid if the tag matches. MODES 1/2 leave the BTB unchanged.
- Counters (MODES 1/2): the index is recomputed from ex_pc and ex_ghr, never the live GHR. The counter saturates: taken increments (3 holds at 3), not-taken decrements (0 holds at 0).
- GHR (MODE 2): shifts left by one with ex_taken in bit 0. This is non-speculative; on a mispredict no repair is needed.
- Performance counters: br_count increments by 1. miss_count increments when mispredict = 1. Both wrap modulo 2^32.

Boundary conditions:
- Lookup and update to the same entry in the same cycle: the lookup returns the pre-update value; the new value is visible next cycle.
- perf_clr together with upd_en: clear wins, so counters read 0 next cycle.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- upd_en = 0 leaves all state unchanged.

Decomposition:
- Shared package holds mode constants (MODE_BTB=0, MODE_BIMODAL=1, MODE_GSHARE=2), the 2-bit counter encoding constants, and the saturating-increment/decrement function.
- One sub-module is natural: bp_sat_counter_table (BHT_ENTRIES x 2-bit array with one async read port, one write port and reset init).
- BTB arrays, GHR and performance counters stay in the top module.

Test Plan:
1. Reset, then pc_f=0x100 -> pred_taken_f=0, pred_npc_f=0x104, br_count=0, miss_count=0.
2. MODE 1, branch at 0x100 resolved taken to 0x80 with ex_pred_taken=0 ->
   - Same cycle: mispredict=1, redirect_pc=0x80.
   - Next cycle: pc_f=0x100 gives pred_taken_f=1, pred_npc_f=0x80 (counter is 2).
3. MODE 1, four not-taken updates at 0x100 (carrying correct predictions) after step 2 ->
   - Counter saturates at 0; pred_npc_f=0x104.
   - BTB entry stays valid; miss_count counts only the first not-taken.
4. MODE 0, hit entry for 0x200, then a not-taken update -> entry invalidated; pc_f=0x200 gives pred_taken_f=0.
5. Aliasing: BTB_ENTRIES=64, taken updates at 0x100 then 0x200 (same index) ->
   - pc_f=0x100 misses (tag mismatch).
   - pc_f=0x200 predicts its own target.
6. MODE 2, GHR_BITS=2: outcomes T,T -> GHR=2'b11.
   - A lookup at 0x100 uses counter index 0x40^0x3.
   - An update carrying ex_ghr=0 touches index 0x40.
   - Assert rst mid-run -> GHR=0 and counters=CTR_INIT without waiting for a clock edge.
